ser_to_par_gen: RTL and testbench

Parametrised serial-to-parallel deserialiser, the generalised successor to the fixed 8-bit converter. It gathers WIDTH serial bits, qualified by a bit-valid strobe, into a word in either bit order. It resynchronises on a frame-start marker and presents each completed word on a valid/ready output port with a one-word holding register and a sticky overrun flag. It sits between a serial line receiver and any word-wide consumer in the datapath.

---
 rtl/ser_to_par_gen.sv | 138 +++++++++++++
 tb/tb_ser_to_par_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ser_to_par_gen.sv
// ser_to_par_gen
//   Parametrised serial-to-parallel deserialiser. Collects WIDTH qualified
//   serial bits into a word (MSB-first or LSB-first), resynchronises on
//   frame_start, and offers each completed word on a valid/ready port backed
//   by a one-word holding register. A word that completes while the holding
//   register is still occupied and not being drained is dropped, and the
//   sticky overrun flag is set.
//
// Parameters
//   WIDTH      word length in bits (2..64)
//   MSB_FIRST  1: first bit lands in par_out[WIDTH-1]; 0: first bit in par_out[0]
//   CW         width of bit_cnt (derived)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   ser_in       serial data bit, sampled when ser_valid=1
//   ser_valid    bit qualifier
//   frame_start  discard partial word and restart
//   par_ready    consumer accepts par_out when par_valid=1
//   overrun_clr  clears the sticky overrun flag
//   par_out      assembled word, stable while par_valid=1
//   par_valid    a word is pending on par_out
//   bit_cnt      bits collected for the current partial word
//   overrun      sticky: a completed word was dropped
module ser_to_par_gen #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             par_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  localparam logic [0:0]    EMPTY    = 1'b0;
  localparam logic [0:0]    FULL     = 1'b1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_p0;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_p0;
  logic [0:0]       state_p1;
  logic [0:0]       state_nxt;
  logic             load;
  logic             drop;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             b);
    if (MSB_FIRST)
      return {cur[WIDTH-2:0], b};
    else
      return {b, cur[WIDTH-1:1]};
  endfunction

  // Stage p0: bit gathering into the shift register
  always_comb begin
    sr_nxt  = sr_p0;
    cnt_nxt = bit_cnt;
    done_p0 = 1'b0;
    if (frame_start) begin
      if (ser_valid) begin
        // The resync bit is the first bit of a fresh word; old contents are
        // zeroed so nothing of the discarded partial word can survive.
        sr_nxt  = shift_in('0, ser_in);
        cnt_nxt = CW'(1);
      end else begin
        sr_nxt  = '0;
        cnt_nxt = '0;
      end
    end else if (ser_valid) begin
      sr_nxt = shift_in(sr_p0, ser_in);
      if (bit_cnt == LAST_BIT) begin
        done_p0 = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = bit_cnt + CW'(1);
      end
    end
  end

  // Stage p1: one-word holding register with valid/ready handshake
  always_comb begin
    state_nxt = state_p1;
    load      = 1'b0;
    drop      = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (done_p0) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (par_ready) begin
          // Drain and refill on the same edge is back-to-back, not a drop.
          if (done_p0)
            load = 1'b1;
          else
            state_nxt = EMPTY;
        end else if (done_p0) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_p0    <= '0;
      bit_cnt  <= '0;
      state_p1 <= EMPTY;
      par_out  <= '0;
      overrun  <= 1'b0;
    end else begin
      sr_p0    <= sr_nxt;
      bit_cnt  <= cnt_nxt;
      state_p1 <= state_nxt;
      if (load)
        par_out <= sr_nxt;
      // A drop on the same edge as a clear leaves the flag set.
      overrun  <= drop | (overrun & ~overrun_clr);
    end
  end

  assign par_valid = (state_p1 == FULL);

endmodule

// File: tb/tb_ser_to_par_gen.sv
module tb_ser_to_par_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=8, MSB first
  logic       ser_in_a, ser_valid_a, frame_start_a, par_ready_a, overrun_clr_a;
  logic [7:0] par_out_a;
  logic       par_valid_a, overrun_a;
  logic [2:0] bit_cnt_a;
  // Instance B: WIDTH=8, LSB first
  logic       ser_in_b, ser_valid_b, frame_start_b, par_ready_b, overrun_clr_b;
  logic [7:0] par_out_b;
  logic       par_valid_b, overrun_b;
  logic [2:0] bit_cnt_b;
  // Instance C: WIDTH=12, MSB first
  logic        ser_in_c, ser_valid_c, frame_start_c, par_ready_c, overrun_clr_c;
  logic [11:0] par_out_c;
  logic        par_valid_c, overrun_c;
  logic [3:0]  bit_cnt_c;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [63:0] q_c[$];

  ser_to_par_gen #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .ser_in(ser_in_a), .ser_valid(ser_valid_a),
    .frame_start(frame_start_a), .par_ready(par_ready_a),
    .overrun_clr(overrun_clr_a), .par_out(par_out_a), .par_valid(par_valid_a),
    .bit_cnt(bit_cnt_a), .overrun(overrun_a));

  ser_to_par_gen #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .ser_in(ser_in_b), .ser_valid(ser_valid_b),
    .frame_start(frame_start_b), .par_ready(par_ready_b),
    .overrun_clr(overrun_clr_b), .par_out(par_out_b), .par_valid(par_valid_b),
    .bit_cnt(bit_cnt_b), .overrun(overrun_b));

  ser_to_par_gen #(.WIDTH(12), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .ser_in(ser_in_c), .ser_valid(ser_valid_c),
    .frame_start(frame_start_c), .par_ready(par_ready_c),
    .overrun_clr(overrun_clr_c), .par_out(par_out_c), .par_valid(par_valid_c),
    .bit_cnt(bit_cnt_c), .overrun(overrun_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: compare at each handshake (valid & ready seen mid-cycle).
  always @(negedge clk) begin
    if (!reset && par_valid_a && par_ready_a) begin
      if (q_a.size() == 0) chk("a_unexpected_word", {56'd0, par_out_a}, 64'hDEAD);
      else chk("a_word", {56'd0, par_out_a}, q_a.pop_front());
    end
    if (!reset && par_valid_b && par_ready_b) begin
      if (q_b.size() == 0) chk("b_unexpected_word", {56'd0, par_out_b}, 64'hDEAD);
      else chk("b_word", {56'd0, par_out_b}, q_b.pop_front());
    end
    if (!reset && par_valid_c && par_ready_c) begin
      if (q_c.size() == 0) chk("c_unexpected_word", {52'd0, par_out_c}, 64'hDEAD);
      else chk("c_word", {52'd0, par_out_c}, q_c.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic b, input logic fs);
    ser_in_a = b; ser_valid_a = 1'b1; frame_start_a = fs;
    step();
    ser_valid_a = 1'b0; frame_start_a = 1'b0;
  endtask

  task automatic send_word_a(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_a(w[i], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w8;
    logic [11:0] w12;
    logic [4:0]  junk;
    logic [6:0]  tail;
    reset = 1'b1;
    {ser_in_a, ser_valid_a, frame_start_a, overrun_clr_a} = '0;
    {ser_in_b, ser_valid_b, frame_start_b, overrun_clr_b} = '0;
    {ser_in_c, ser_valid_c, frame_start_c, overrun_clr_c} = '0;
    par_ready_a = 1'b1; par_ready_b = 1'b1; par_ready_c = 1'b1;
    step(); step();
    reset = 1'b0;

    chk("rst_par_out", {56'd0, par_out_a}, 64'd0);
    chk("rst_par_valid", {63'd0, par_valid_a}, 64'd0);
    chk("rst_bit_cnt", {61'd0, bit_cnt_a}, 64'd0);
    chk("rst_overrun", {63'd0, overrun_a}, 64'd0);

    // Basic word, consecutive bits, pulse length and latency
    w8 = 8'h3D;
    q_a.push_back(64'h3D);
    for (int i = 7; i >= 0; i--) begin
      chk("basic_cnt", {61'd0, bit_cnt_a}, 64'(7 - i));
      chk("basic_valid_low", {63'd0, par_valid_a}, 64'd0);
      send_a(w8[i], 1'b0);
    end
    chk("basic_valid_rise", {63'd0, par_valid_a}, 64'd1);
    chk("basic_out", {56'd0, par_out_a}, 64'h3D);
    chk("basic_cnt_wrap", {61'd0, bit_cnt_a}, 64'd0);
    step();
    chk("basic_valid_pulse", {63'd0, par_valid_a}, 64'd0);

    // ser_valid gaps
    q_a.push_back(64'h3D);
    for (int i = 7; i >= 0; i--) begin
      send_a(w8[i], 1'b0);
      step();
      chk("gap_cnt_hold", {61'd0, bit_cnt_a}, 64'((8 - i) % 8));
    end
    step();

    // Frame resync discards the partial word
    junk = 5'b10110;
    for (int i = 4; i >= 0; i--) send_a(junk[i], 1'b0);
    chk("fs_partial_cnt", {61'd0, bit_cnt_a}, 64'd5);
    q_a.push_back(64'h3D);
    send_a(1'b0, 1'b1);
    chk("fs_cnt", {61'd0, bit_cnt_a}, 64'd1);
    tail = 7'b0111101;
    for (int i = 6; i >= 0; i--) send_a(tail[i], 1'b0);
    chk("fs_valid", {63'd0, par_valid_a}, 64'd1);
    step();

    // Overrun with consumer stalled
    par_ready_a = 1'b0;
    q_a.push_back(64'h3D);
    send_word_a(8'h3D);
    chk("ovr_not_yet", {63'd0, overrun_a}, 64'd0);
    send_word_a(8'hBC);
    chk("ovr_hold_out", {56'd0, par_out_a}, 64'h3D);
    chk("ovr_valid", {63'd0, par_valid_a}, 64'd1);
    chk("ovr_set", {63'd0, overrun_a}, 64'd1);
    par_ready_a = 1'b1;
    step();
    chk("ovr_drain_valid", {63'd0, par_valid_a}, 64'd0);
    chk("ovr_sticky", {63'd0, overrun_a}, 64'd1);
    overrun_clr_a = 1'b1;
    step();
    overrun_clr_a = 1'b0;
    chk("ovr_clr", {63'd0, overrun_a}, 64'd0);

    // Accept on the exact edge the next word completes
    par_ready_a = 1'b0;
    q_a.push_back(64'h3D);
    send_word_a(8'h3D);
    w8 = 8'hBC;
    for (int i = 7; i >= 1; i--) send_a(w8[i], 1'b0);
    par_ready_a = 1'b1;
    q_a.push_back(64'hBC);
    send_a(w8[0], 1'b0);
    par_ready_a = 1'b0;
    chk("b2b_out", {56'd0, par_out_a}, 64'hBC);
    chk("b2b_valid", {63'd0, par_valid_a}, 64'd1);
    chk("b2b_no_ovr", {63'd0, overrun_a}, 64'd0);

    // Drop another word so overrun is set, then reset mid-word
    send_word_a(8'h55);
    chk("pre_rst_ovr", {63'd0, overrun_a}, 64'd1);
    send_a(1'b1, 1'b0); send_a(1'b1, 1'b0); send_a(1'b0, 1'b0);
    do_reset();
    q_a.delete();
    chk("mid_rst_out", {56'd0, par_out_a}, 64'd0);
    chk("mid_rst_valid", {63'd0, par_valid_a}, 64'd0);
    chk("mid_rst_cnt", {61'd0, bit_cnt_a}, 64'd0);
    chk("mid_rst_ovr", {63'd0, overrun_a}, 64'd0);
    par_ready_a = 1'b1;

    // LSB-first bit order
    w8 = 8'h3D;
    q_b.push_back(64'hBC);
    for (int i = 7; i >= 0; i--) begin
      ser_in_b = w8[i]; ser_valid_b = 1'b1;
      step();
    end
    ser_valid_b = 1'b0;
    chk("lsb_out", {56'd0, par_out_b}, 64'hBC);
    chk("lsb_valid", {63'd0, par_valid_b}, 64'd1);

    // 12-bit word
    w12 = 12'hA03;
    q_c.push_back(64'hA03);
    for (int i = 11; i >= 0; i--) begin
      ser_in_c = w12[i]; ser_valid_c = 1'b1;
      step();
    end
    ser_valid_c = 1'b0;
    chk("w12_out", {52'd0, par_out_c}, 64'hA03);
    chk("w12_cnt", {60'd0, bit_cnt_c}, 64'd0);
    step(); step();

    chk("a_q_empty", 64'(q_a.size()), 64'd0);
    chk("b_q_empty", 64'(q_b.size()), 64'd0);
    chk("c_q_empty", 64'(q_c.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
